uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
Parametrised full-duplex UART transceiver for the sensor link. Replaces the fixed 8-bit TX/RX pair driven from a divided clock. Runs on the system clock with an internal per-bit cycle counter, and supports configurable data width and stop-bit count. Reports a framing error, and optionally generates and checks parity. Sits between the sensor/command logic and the board serial pins; the top level can loop tx_serial to rx_serial for self-test.

Parameters:
CLKS_PER_BIT, 434, system clock cycles per serial bit (>= 4); 434 gives 115200 baud at 50 MHz
DATA_BITS, 8, payload bits per frame (5..9), sent LSB first
STOP_BITS, 1, stop bits generated by TX (1 or 2); RX checks only the first
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_PARITY_EN is defined

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
tx_start  in  1  request to send tx_data; accepted only in TX IDLE
tx_data  in  DATA_BITS  payload, latched on the accept cycle
tx_busy  out  1  high while a frame is being shifted out
tx_done  out  1  one-cycle pulse at end of frame
tx_serial  out  1  serial output, idle high
rx_serial  in  1  asynchronous serial input
rx_valid  out  1  one-cycle pulse, rx_data updated
rx_data  out  DATA_BITS  last correctly framed payload
rx_frame_error  out  1  one-cycle pulse, stop bit sampled low
rx_parity_error  out  1  one-cycle pulse, parity mismatch (constant 0 without macro)

Behaviour:
- Reset (synchronous, active-high), effective the cycle after reset is sampled high:
  - tx_serial=1; tx_busy, tx_done, rx_valid, rx_frame_error, rx_parity_error=0; rx_data=0.
  - Both FSMs go to IDLE and all counters clear. This applies even mid-frame; a TX frame aborted by reset is not completed.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Accept: tx_start=1 in IDLE latches tx_data. The next cycle has tx_serial=0 and tx_busy=1.
  - Each bit is held exactly CLKS_PER_BIT cycles. DATA shifts DATA_BITS bits LSB first. STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - Total frame is (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
  - On the first cycle back in IDLE: tx_done=1 for one cycle and tx_busy=0.
  - tx_start in that same cycle is accepted, giving back-to-back frames with no idle gap.
  - tx_start while busy is ignored and is not queued. tx_data changes after accept have no effect.
- RX path: rx_serial passes through a 2-flop synchroniser; all decisions use the synchronised signal.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, plus a BREAK state.
  - IDLE: a synchronised low enters START, counter cleared.
  - START: after CLKS_PER_BIT/2 cycles (integer division), resample. If high, it was a glitch: return to IDLE with no outputs. If low, continue.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), DATA_BITS samples, shifted LSB first.
  - PARITY (macro only): one mid-bit sample.
  - STOP: one mid-bit sample.
    - High: the next cycle rx_data is updated and rx_valid=1 for one cycle, then IDLE.
    - Low: the next cycle rx_frame_error=1, rx_data is unchanged, then BREAK.
  - BREAK: wait for synchronised rx_serial=1, then IDLE. A line held low produces only one error.
- Outputs: rx_valid and rx_frame_error are never high in the same cycle.
- TX and RX are fully independent; simultaneous activity is allowed.

Optional Feature:
Macro: UART_PARITY_EN.
- Defined:
  - TX inserts one parity bit after the data bits: XOR of the data for even parity, inverted XOR for odd.
  - RX samples the parity bit and compares it. On mismatch, rx_parity_error pulses in the same cycle as rx_valid, and rx_data is still updated.
  - A framing error takes precedence: no rx_parity_error pulse is produced with rx_frame_error.
- Undefined: there is no PARITY state, frames carry no parity bit, and rx_parity_error is tied to 0.

Test Plan:
1. Loopback, CLKS_PER_BIT=4, tx_data=8'h4F, one tx_start pulse:
   - tx_serial low for exactly 4 cycles, then bits 1,1,1,1,0,0,1,0, then high.
   - tx_done after 40 cycles.
   - Exactly one rx_valid with rx_data=8'h4F.
2. Back-to-back: 8'h00, then tx_start held high through the tx_done cycle with 8'hFF:
   - No idle gap between frames.
   - rx_valid twice, with 8'h00 then 8'hFF.
   - A tx_start pulse mid-frame is ignored.
3. Glitch: rx_serial low for 1 cycle (CLKS_PER_BIT=8) -> no rx_valid, no error, RX returns to IDLE.
4. Framing: drive a frame for 8'hA5 with the stop bit low, then hold the line low for 3 bit times:
   - Exactly one rx_frame_error pulse and no rx_valid.
   - rx_data keeps its previous value.
   - The next good frame, 8'h3C, is received.
5. Reset mid-frame: assert reset during TX data bit 3:
   - The next cycle, tx_serial=1 and tx_busy=0.
   - No tx_done, no rx_valid.
   - A new frame after reset transmits correctly.
6. UART_PARITY_EN, PARITY_ODD=0:
   - Send 8'h07: parity bit = 1.
   - Inject frame 8'h07 with parity bit 0 -> rx_valid and rx_parity_error in the same cycle, rx_data=8'h07.

Source files
------------

// File: rtl/uart_transceiver_if.sv
// Serial-link bundle for uart_transceiver.
// Signals:
//   tx_start/tx_data      : frame request and payload (master -> transceiver)
//   tx_busy/tx_done       : TX status, tx_done is a one-cycle end-of-frame pulse
//   tx_serial/rx_serial   : board serial pins (idle high)
//   rx_valid/rx_data      : received payload and its one-cycle strobe
//   rx_frame_error        : one-cycle pulse, stop bit sampled low
//   rx_parity_error       : one-cycle pulse alongside rx_valid on parity mismatch
// Modport slave is the transceiver side; master is the user/pin side.
interface uart_transceiver_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx_serial;
  logic                 rx_serial;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_error;
  logic                 rx_parity_error;

  modport slave (
    input  tx_start, tx_data, rx_serial,
    output tx_busy, tx_done, tx_serial, rx_valid, rx_data, rx_frame_error, rx_parity_error
  );

  modport master (
    output tx_start, tx_data, rx_serial,
    input  tx_busy, tx_done, tx_serial, rx_valid, rx_data, rx_frame_error, rx_parity_error
  );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex UART running on the system clock with per-bit cycle counters.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : uart_transceiver_if.slave (TX request/status, serial pins, RX results)
// Parameters: CLKS_PER_BIT (>= 4), DATA_BITS (5..9, LSB first), STOP_BITS (1 or 2),
// PARITY_ODD (0 even / 1 odd).
// Optional feature: define UART_PARITY_EN to add a parity bit to TX frames and check it on RX.
module uart_transceiver #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input logic               clock,
  input logic               reset,
  uart_transceiver_if.slave bus
);

  localparam int unsigned CntW = $clog2(2 * CLKS_PER_BIT + 1);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
  // The IDLE cycle that carries tx_done doubles as the last stop-bit cycle, so a frame
  // accepted there follows with no extra high cycle.
  localparam logic [CntW-1:0] StopEnd = CntW'(STOP_BITS * CLKS_PER_BIT - 2);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
  localparam logic ParOdd = 1'(PARITY_ODD);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
`endif

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {
    TxIdle, TxStart, TxData,
`ifdef UART_PARITY_EN
    TxParity,
`endif
    TxStop
  } tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [BitW-1:0]      tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 tx_done_q, tx_done_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (bus.tx_start) begin
          tx_state_d = TxStart;
          tx_shift_d = bus.tx_data;
`ifdef UART_PARITY_EN
          tx_par_d   = (^bus.tx_data) ^ ParOdd;
`endif
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LastBit) begin
`ifdef UART_PARITY_EN
            tx_state_d = TxParity;
`else
            tx_state_d = TxStop;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      TxParity: begin
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d   = '0;
          tx_state_d = TxStop;
        end
      end
`endif
      TxStop: begin
        if (tx_cnt_q == StopEnd) begin
          tx_state_d = TxIdle;
          tx_done_d  = 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    // Pin is registered from the next state so it never glitches.
    case (tx_state_d)
      TxStart:  tx_serial_d = 1'b0;
      TxData:   tx_serial_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
      TxParity: tx_serial_d = tx_par_d;
`endif
      default:  tx_serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_serial_q <= 1'b1;
      tx_done_q   <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q    <= 1'b0;
`endif
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_serial_q <= tx_serial_d;
      tx_done_q   <= tx_done_d;
`ifdef UART_PARITY_EN
      tx_par_q    <= tx_par_d;
`endif
    end
  end

  assign bus.tx_serial = tx_serial_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.tx_busy   = (tx_state_q != TxIdle);

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData,
`ifdef UART_PARITY_EN
    RxParity,
`endif
    RxStop, RxBreak
  } rx_state_e;

  logic                 rx_meta_q, rx_sync_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [BitW-1:0]      rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d;
  logic                 rx_perr_q, rx_perr_d;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
    rx_perr_d  = 1'b0;
`endif
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        // Half-bit recheck rejects glitches and aligns later samples to mid-bit.
        if (rx_cnt_q == HalfEnd) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitEnd) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LastBit) begin
`ifdef UART_PARITY_EN
            rx_state_d = RxParity;
`else
            rx_state_d = RxStop;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RxParity: begin
        if (rx_cnt_q == BitEnd) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = RxStop;
        end
      end
`endif
      RxStop: begin
        if (rx_cnt_q == BitEnd) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_PARITY_EN
            rx_perr_d  = rx_par_q ^ (^rx_shift_q) ^ ParOdd;
`endif
            rx_state_d = RxIdle;
          end else begin
            rx_ferr_d  = 1'b1;
            rx_state_d = RxBreak;
          end
        end
      end
      RxBreak: begin
        // Held-low line reports one error; wait for it to return high.
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= bus.rx_serial;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign bus.rx_data        = rx_data_q;
  assign bus.rx_valid       = rx_valid_q;
  assign bus.rx_frame_error = rx_ferr_q;
`ifdef UART_PARITY_EN
  assign bus.rx_parity_error = rx_perr_q;
`else
  assign bus.rx_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver.
// dut4: CLKS_PER_BIT=4 with tx_serial looped to rx_serial.
// dut8: CLKS_PER_BIT=8, rx_serial driven directly by the bench.
module tb_uart_transceiver;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_transceiver_if #(.DATA_BITS(8)) bus4 ();
  uart_transceiver_if #(.DATA_BITS(8)) bus8 ();

  uart_transceiver #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  uart_transceiver #(.CLKS_PER_BIT(8), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  assign bus4.rx_serial = bus4.tx_serial;

  int n_cmp = 0;
  int n_err = 0;

`ifdef UART_PARITY_EN
  logic rx8_par_flip = 1'b0;
`endif

  // Pulse monitors, sampled at the rising edge before the flops update.
  int         tx4_done_cnt = 0;
  int         rx4_valid_cnt = 0;
  int         rx4_ferr_cnt = 0;
  int         rx4_perr_cnt = 0;
  int         rx8_valid_cnt = 0;
  int         rx8_ferr_cnt = 0;
  int         rx8_perr_cnt = 0;
  int         rx8_vp_cnt = 0;
  int         overlap_cnt = 0;
  logic [7:0] rx4_q[$];

  always @(posedge clock) begin
    if (bus4.tx_done) tx4_done_cnt++;
    if (bus4.rx_valid) begin
      rx4_valid_cnt++;
      rx4_q.push_back(bus4.rx_data);
    end
    if (bus4.rx_frame_error) rx4_ferr_cnt++;
    if (bus4.rx_parity_error) rx4_perr_cnt++;
    if (bus8.rx_valid) rx8_valid_cnt++;
    if (bus8.rx_frame_error) rx8_ferr_cnt++;
    if (bus8.rx_parity_error) rx8_perr_cnt++;
    if (bus8.rx_valid && bus8.rx_parity_error) rx8_vp_cnt++;
    if ((bus4.rx_valid && bus4.rx_frame_error) || (bus8.rx_valid && bus8.rx_frame_error))
      overlap_cnt++;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected pin waveform at 4 cycles per bit; pat[i] is the level of bit period i.
  function automatic logic [87:0] expand(input logic [21:0] pat, input int nper);
    logic [87:0] w;
    w = '0;
    for (int n = 0; n < nper * 4; n++) w[n] = pat[n / 4];
    return w;
  endfunction

  // Drives one frame into dut8 (8 cycles per bit); the line is left at the stop level.
  task automatic send8(input logic [7:0] d, input logic stop);
    bus8.rx_serial = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      bus8.rx_serial = d[i];
      repeat (8) tick();
    end
`ifdef UART_PARITY_EN
    bus8.rx_serial = (^d) ^ rx8_par_flip;
    repeat (8) tick();
`endif
    bus8.rx_serial = stop;
    repeat (8) tick();
  endtask

  logic [87:0] obs_w, obs_d, obs_b;
  int          base_done, base_valid, base_q, base_v8;

  initial begin
    bus4.tx_start  = 1'b0;
    bus4.tx_data   = 8'h00;
    bus8.tx_start  = 1'b0;
    bus8.tx_data   = 8'h00;
    bus8.rx_serial = 1'b1;

    // Reset state
    repeat (3) tick();
    chk1("rst tx_serial", bus4.tx_serial, 1'b1);
    chk1("rst tx_busy", bus4.tx_busy, 1'b0);
    chk1("rst tx_done", bus4.tx_done, 1'b0);
    chk1("rst rx_valid", bus4.rx_valid, 1'b0);
    chk1("rst rx_ferr", bus4.rx_frame_error, 1'b0);
    chk1("rst rx_perr", bus4.rx_parity_error, 1'b0);
    chk8("rst rx_data", bus4.rx_data, 8'h00);
    reset = 1'b0;
    repeat (3) tick();

`ifndef UART_PARITY_EN
    // 1: single 8'h4F frame, loopback
    bus4.tx_data  = 8'h4F;
    bus4.tx_start = 1'b1;
    tick();
    bus4.tx_start = 1'b0;
    obs_w = '0; obs_d = '0; obs_b = '0;
    for (int n = 0; n < 40; n++) begin
      obs_w[n] = bus4.tx_serial;
      obs_d[n] = bus4.tx_done;
      obs_b[n] = bus4.tx_busy;
      tick();
    end
    chkw("t1 tx waveform", obs_w, expand(22'b1010011110, 10));
    chkw("t1 tx_done timing", obs_d, 88'h80_0000_0000);
    chkw("t1 tx_busy timing", obs_b, 88'h7F_FFFF_FFFF);
    repeat (10) tick();
    chkn("t1 rx_valid count", rx4_valid_cnt, 1);
    chk8("t1 rx_data", bus4.rx_data, 8'h4F);
    chkn("t1 tx_done count", tx4_done_cnt, 1);

    // 2: back-to-back 8'h00 then 8'hFF, with an ignored mid-frame request
    base_q = rx4_q.size();
    bus4.tx_data  = 8'h00;
    bus4.tx_start = 1'b1;
    tick();
    bus4.tx_start = 1'b0;
    obs_w = '0;
    for (int n = 0; n < 80; n++) begin
      obs_w[n] = bus4.tx_serial;
      if (n == 9) begin
        bus4.tx_data  = 8'h55;
        bus4.tx_start = 1'b1;
      end
      if (n == 10) bus4.tx_start = 1'b0;
      if (n == 37) begin
        bus4.tx_data  = 8'hFF;
        bus4.tx_start = 1'b1;
      end
      if (n == 40) bus4.tx_start = 1'b0;
      tick();
    end
    chkw("t2 tx waveform", obs_w, expand(22'b1111111110_1000000000, 20));
    repeat (12) tick();
    chkn("t2 tx_done count", tx4_done_cnt, 3);
    chkn("t2 rx_valid count", rx4_q.size(), base_q + 2);
    chk8("t2 first rx_data", rx4_q[base_q], 8'h00);
    chk8("t2 second rx_data", rx4_q[base_q + 1], 8'hFF);
`endif

    // 3: one-cycle glitch on dut8
    bus8.rx_serial = 1'b0;
    tick();
    bus8.rx_serial = 1'b1;
    repeat (30) tick();
    chkn("t3 glitch rx_valid", rx8_valid_cnt, 0);
    chkn("t3 glitch rx_ferr", rx8_ferr_cnt, 0);

    // 4: good frame, framing error with held-low line, then good frame
    send8(8'h96, 1'b1);
    repeat (10) tick();
    chkn("t4 pre rx_valid", rx8_valid_cnt, 1);
    chk8("t4 pre rx_data", bus8.rx_data, 8'h96);
    send8(8'hA5, 1'b0);
    repeat (24) tick();
    bus8.rx_serial = 1'b1;
    repeat (20) tick();
    chkn("t4 ferr count", rx8_ferr_cnt, 1);
    chkn("t4 no rx_valid", rx8_valid_cnt, 1);
    chk8("t4 rx_data kept", bus8.rx_data, 8'h96);
    send8(8'h3C, 1'b1);
    repeat (10) tick();
    chkn("t4 post rx_valid", rx8_valid_cnt, 2);
    chk8("t4 post rx_data", bus8.rx_data, 8'h3C);
    chkn("t4 post ferr", rx8_ferr_cnt, 1);

    // 5: reset during TX data bit 3 (frame cycles 17..20)
    bus4.tx_data  = 8'hC3;
    bus4.tx_start = 1'b1;
    tick();
    bus4.tx_start = 1'b0;
    repeat (17) tick();
    chk1("t5 busy before reset", bus4.tx_busy, 1'b1);
    base_done  = tx4_done_cnt;
    base_valid = rx4_valid_cnt;
    reset = 1'b1;
    tick();
    chk1("t5 tx_serial after reset", bus4.tx_serial, 1'b1);
    chk1("t5 tx_busy after reset", bus4.tx_busy, 1'b0);
    reset = 1'b0;
    repeat (60) tick();
    chkn("t5 no tx_done", tx4_done_cnt, base_done);
    chkn("t5 no rx_valid", rx4_valid_cnt, base_valid);
    bus4.tx_data  = 8'h5A;
    bus4.tx_start = 1'b1;
    tick();
    bus4.tx_start = 1'b0;
    repeat (55) tick();
    chkn("t5 new tx_done", tx4_done_cnt, base_done + 1);
    chkn("t5 new rx_valid", rx4_valid_cnt, base_valid + 1);
    chk8("t5 new rx_data", bus4.rx_data, 8'h5A);

`ifdef UART_PARITY_EN
    // 6: even parity, 8'h07 carries parity bit 1
    bus4.tx_data  = 8'h07;
    bus4.tx_start = 1'b1;
    tick();
    bus4.tx_start = 1'b0;
    obs_w = '0; obs_d = '0;
    for (int n = 0; n < 44; n++) begin
      obs_w[n] = bus4.tx_serial;
      obs_d[n] = bus4.tx_done;
      tick();
    end
    chkw("t6 tx waveform", obs_w, expand(22'b11000001110, 11));
    chkw("t6 tx_done timing", obs_d, 88'h800_0000_0000);
    repeat (12) tick();
    chk8("t6 loopback rx_data", bus4.rx_data, 8'h07);
    chkn("t6 loopback perr", rx4_perr_cnt, 0);
    base_v8 = rx8_valid_cnt;
    rx8_par_flip = 1'b1;
    send8(8'h07, 1'b1);
    rx8_par_flip = 1'b0;
    repeat (10) tick();
    chkn("t6 rx_valid", rx8_valid_cnt, base_v8 + 1);
    chkn("t6 perr with valid", rx8_vp_cnt, 1);
    chk8("t6 rx_data", bus8.rx_data, 8'h07);
`endif

    chkn("rx_parity_error pulses dut8", rx8_perr_cnt,
`ifdef UART_PARITY_EN
         1
`else
         0
`endif
    );
    chkn("dut4 frame errors", rx4_ferr_cnt, 0);
    chkn("valid/ferr overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
